rd_rsp_checker: RTL

RD_RSP_CHECKER -- requirements
Module: rd_rsp_checker

---
 rtl/rdchk_pkg.sv | 19 +
 rtl/rdchk_pattern_gen.sv | 21 ++
 rtl/rd_rsp_checker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rdchk_pkg.sv
// Shared types, ErrorInfo field offsets and expected-line geometry for the read-response checker.
package rdchk_pkg;

  typedef enum logic [1:0] {StIdle, StCheck, StDone} rdchk_state_e;

  localparam int unsigned LineW      = 512;
  localparam int unsigned ErrActLo   = 0;
  localparam int unsigned ErrExpLo   = 64;
  localparam int unsigned ErrCntLo   = 128;
  localparam int unsigned ErrHdrLo   = 160;
  localparam int unsigned ErrAddrLo  = 176;
  localparam int unsigned ErrFlagBit = 255;

  // Marker sits just above the 416 zero bits and 31 pad bits over {~addr, addr}.
  function automatic int unsigned marker_pos(input int unsigned addr_lmt);
    return 447 + 2 * addr_lmt;
  endfunction

endpackage

// File: rtl/rdchk_pattern_gen.sv
// Expected cache-line generator: {msb, pad, ~addr, addr} zero-extended to a full line.
module rdchk_pattern_gen
  import rdchk_pkg::*;
#(
  parameter int unsigned ADDR_LMT = 20
) (
  input  logic [ADDR_LMT-1:0] addr,
  input  logic                msb,
  output logic [LineW-1:0]    line
);

  localparam int unsigned MarkPos = marker_pos(ADDR_LMT);

  always_comb begin
    line                         = '0;
    line[ADDR_LMT-1:0]           = addr;
    line[2*ADDR_LMT-1:ADDR_LMT]  = ~addr;
    line[MarkPos]                = msb;
  end

endmodule

// File: rtl/rd_rsp_checker.sv
// Two-stage read-response checker. Build with RDCHK_FULL_CL_EN to compare all 512 line bits;
// otherwise only the address fields and the marker bit are compared.
module rd_rsp_checker
  import rdchk_pkg::*;
#(
  parameter int unsigned ADDR_LMT = 20,
  parameter int unsigned MDATA    = 14
) (
  input  logic                Clk_400,
  input  logic                test_Resetb,
  input  logic [1:0]          ab2rw_Mode,
  input  logic                re2xy_go,
  input  logic [31:0]         re2xy_NumLines,
  input  logic                re2xy_Cont,
  input  logic                re2xy_wrdin_msb,
  input  logic                ab2rw_RdRspValid,
  input  logic [15:0]         ab2rw_RdRsp,
  input  logic [ADDR_LMT-1:0] ab2rw_RdRspAddr,
  input  logic [511:0]        ab2rw_RdData,
  output logic                ck2ab_ErrorValid,
  output logic [255:0]        ck2ab_ErrorInfo,
  output logic [15:0]         ck2ab_ErrCnt,
  output logic [31:0]         ck2ab_RspCnt,
  output logic                ck2ab_Done
);

  localparam int unsigned MarkPos = marker_pos(ADDR_LMT);

  rdchk_state_e state_q, state_d;

  logic                s1_valid_q;
  logic [ADDR_LMT-1:0] s1_addr_q;
  logic [MDATA-1:0]    s1_hdr_q;
  logic [LineW-1:0]    s1_data_q;

  logic [LineW-1:0] exp_line, cmp_mask;
  logic [255:0]     err_info_d, err_info_q;
  logic [31:0]      rsp_cnt_q, cnt_inc;
  logic [15:0]      err_cnt_q;
  logic             err_valid_q, err_seen_q, done_q, done_d;
  logic             accept, chk, last_rsp, mismatch;
  logic             unused_bits;

  // Mode[1] and header bits above the tag carry nothing the checker needs.
  assign unused_bits = ^{ab2rw_Mode[1], ab2rw_RdRsp};

  rdchk_pattern_gen #(
    .ADDR_LMT (ADDR_LMT)
  ) u_pattern_gen (
    .addr (s1_addr_q),
    .msb  (re2xy_wrdin_msb),
    .line (exp_line)
  );

  // FSM: state register
  always_ff @(posedge Clk_400 or negedge test_Resetb) begin
    if (!test_Resetb) state_q <= StIdle;
    else              state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (re2xy_go) begin
          state_d = (re2xy_NumLines != 32'd0 && ab2rw_Mode[0]) ? StCheck : StDone;
        end
      end
      StCheck: if (chk && last_rsp && !re2xy_Cont) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    accept = ab2rw_RdRspValid && (state_q == StCheck);
    chk    = s1_valid_q && (state_q == StCheck);
    done_d = (state_q == StDone);
  end

  assign cnt_inc  = rsp_cnt_q + 32'd1;
  assign last_rsp = (cnt_inc == re2xy_NumLines);

  always_comb begin
`ifdef RDCHK_FULL_CL_EN
    cmp_mask = '1;
`else
    cmp_mask                    = '0;
    cmp_mask[2*ADDR_LMT-1:0]    = '1;
    cmp_mask[MarkPos]           = 1'b1;
`endif
  end

  assign mismatch = |((s1_data_q ^ exp_line) & cmp_mask);

  always_comb begin
    err_info_d                     = '0;
    err_info_d[ErrActLo +: 64]     = s1_data_q[63:0];
    err_info_d[ErrExpLo +: 64]     = exp_line[63:0];
    err_info_d[ErrCntLo +: 32]     = rsp_cnt_q;
    err_info_d[ErrHdrLo +: 16]     = 16'(s1_hdr_q);
    err_info_d[ErrAddrLo +: 32]    = 32'(s1_addr_q);
    err_info_d[ErrFlagBit]         = s1_data_q[MarkPos] ^ exp_line[MarkPos];
  end

  // Stage 1: register the response
  always_ff @(posedge Clk_400 or negedge test_Resetb) begin
    if (!test_Resetb) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_hdr_q   <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= ab2rw_RdRspAddr;
        s1_hdr_q  <= ab2rw_RdRsp[MDATA-1:0];
        s1_data_q <= ab2rw_RdData;
      end
    end
  end

  // Stage 2: compare and update counters / first-error capture
  always_ff @(posedge Clk_400 or negedge test_Resetb) begin
    if (!test_Resetb) begin
      rsp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_info_q  <= '0;
      err_valid_q <= 1'b0;
      err_seen_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      done_q      <= done_d;
      if (chk) begin
        rsp_cnt_q <= (last_rsp && re2xy_Cont) ? 32'd0 : cnt_inc;
        if (mismatch) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          if (!err_seen_q) begin
            err_seen_q  <= 1'b1;
            err_valid_q <= 1'b1;
            err_info_q  <= err_info_d;
          end
        end
      end
    end
  end

  assign ck2ab_ErrorValid = err_valid_q;
  assign ck2ab_ErrorInfo  = err_info_q;
  assign ck2ab_ErrCnt     = err_cnt_q;
  assign ck2ab_RspCnt     = rsp_cnt_q;
  assign ck2ab_Done       = done_q;

endmodule
